// File: rtl/irq_pending_capture_if.sv
// Bus bundle between the request-capture stage and its consumer.
// The consumer (master) drives request levels, mask and acknowledge;
// the capture stage (slave) returns the pending vector and status flags.
interface irq_pending_capture_if #(
    parameter int N     = 4,
    parameter int IDX_W = 2
);
    logic [N-1:0]     irq_in;
    logic [N-1:0]     mask;
    logic [N-1:0]     pend;
    logic             pend_valid;
    logic             ack;
    logic [IDX_W-1:0] ack_idx;
    logic             ack_err;
    logic [N-1:0]     overflow;
    logic             clr_ovf;

    modport master (
        output irq_in, mask, ack, ack_idx, clr_ovf,
        input  pend, pend_valid, ack_err, overflow
    );

    modport slave (
        input  irq_in, mask, ack, ack_idx, clr_ovf,
        output pend, pend_valid, ack_err, overflow
    );
endinterface

// File: rtl/irq_pending_capture.sv
// Request-capture stage feeding a priority encoder: rising edges on the raw
// request lines are latched into a pending register, exposed through a mask,
// and cleared when the consumer acknowledges the encoder's index. Edges that
// land on an already-pending line are recorded in sticky overflow flags.
module irq_pending_capture #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    irq_pending_capture_if.slave  bus
);

    logic [N-1:0] irq_q,  irq_d;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] ovf_q,  ovf_d;
    logic         ack_err_q, ack_err_d;

    logic [N-1:0] rise;
    logic [N-1:0] pend_vis;
    logic [N-1:0] ack_vec;
    logic [N-1:0] ack_ok;

    // Next-state logic: edge detect, ack qualification, pending/overflow update.
    always_comb begin
        // NOTE: every signal gets a default before any conditional write so
        // no path leaves it unassigned, which would infer a latch.
        ack_vec = '0;
        if (bus.ack) begin
            ack_vec[bus.ack_idx] = 1'b1;
        end

        rise     = bus.irq_in & ~irq_q;
        pend_vis = pend_q & ~bus.mask;
        // An ack only counts when its index is both pending and visible.
        ack_ok   = ack_vec & pend_vis;

        // A fresh edge wins over a same-edge ack: it is a new event to service.
        pend_d    = rise | (pend_q & ~ack_ok);
        // Set beats clear so an edge lost on the clearing cycle is still flagged.
        ovf_d     = (bus.clr_ovf ? '0 : ovf_q) | (rise & pend_q & ~ack_ok);
        ack_err_d = bus.ack & ~(|ack_ok);
        irq_d     = bus.irq_in;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from values sampled before the edge.
        if (!rst_n) begin
            // Previous sample starts high so lines already asserted at reset
            // release do not look like fresh edges.
            irq_q     <= '1;
            pend_q    <= '0;
            ovf_q     <= '0;
            ack_err_q <= 1'b0;
        end else begin
            irq_q     <= irq_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign bus.pend       = pend_vis;
    assign bus.pend_valid = |pend_vis;
    assign bus.ack_err    = ack_err_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: doc/irq_pending_capture.md
Name: irq_pending_capture

Overview:
- Request-capture stage that sits directly upstream of the 4-to-2 priority encoder.
- Detects rising edges on 4 raw request lines and holds them in a pending register until serviced.
- Presents the masked pending vector to the encoder's d[3:0] input.
- Clears the serviced bit when the consumer acknowledges with the encoder's y[1:0] index; flags lost events via sticky overflow bits.

Parameters:
- N, 4, number of request lines; the design is verified at 4 only.
- IDX_W, 2, width of the acknowledge index (log2 N).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- irq_in  input  N  raw request levels, synchronous to clk.
- mask  input  N  1 = line blocked from pend output (still captured).
- pend  output  N  pend_r & ~mask, combinational; drives encoder d[3:0].
- pend_valid  output  1  |pend, combinational.
- ack  input  1  consumer has serviced index ack_idx this cycle.
- ack_idx  input  IDX_W  index being serviced (encoder y[1:0]).
- ack_err  output  1  registered one-cycle pulse: ack arrived for a non-pending or masked index.
- overflow  output  N  sticky per-line flag: an edge arrived while that line was already pending.
- clr_ovf  input  1  clears all overflow bits.

Behaviour:
- Reset, sampled when rst_n=0 at a clk edge:
  - pend_r=0, overflow=0, ack_err=0.
  - irq_q (previous-sample register) = all 1s, so lines already high at reset release generate no event.
- Edge detect: rise[i] = irq_in[i] & ~irq_q[i], evaluated at each clk edge. irq_q <= irq_in every cycle.
- Latency: irq_in[i] first sampled high at edge k -> pend_r[i]=1 after edge k, so pend is visible in the cycle following edge k.
- Level held high: one event only. A new event requires a low sample first, i.e. a minimum 1-cycle low gap.
- Ack is valid when ack=1 and pend[ack_idx]=1 (pending and unmasked).
  - Valid ack clears pend_r[ack_idx] at that edge.
  - Invalid ack: no state change; ack_err=1 for exactly the next cycle.
  - ack_err is 0 whenever ack=0.
- Per-bit next-state priority for pend_r[i]:
  - rise[i] -> 1, even when a valid ack of i occurs the same edge; this is a new event and is not an overflow.
  - else valid ack of i -> 0.
  - else hold.
- Overflow:
  - overflow[i] sets when rise[i]=1, pend_r[i]=1, and no valid ack of i occurs the same edge.
  - clr_ovf clears all bits; a set on the same edge wins for that bit.
- Mask:
  - Purely output gating; masked lines keep capturing and can overflow.
  - Unmasking an already-pending line makes it visible on pend combinationally, with no clock needed.
- Acks of other indices never affect bit i. Multiple rises on the same edge set all corresponding bits.
- Reset mid-operation: pending events and overflow are discarded; ack and clr_ovf are ignored while rst_n=0.
- Encoder contract: ack_idx must equal the encoder output for the current pend. The block does not re-check priority; any pending unmasked index is a valid ack.

Test Plan:
- Reset release with irq_in=4'b0101 held high -> pend=0, pend_valid=0 for 5 cycles; drop to 0, raise bit2 -> pend=4'b0100 one cycle after the first high sample.
- Pulses on bits 0,1,3 on the same edge -> pend=4'b1011; ack idx 3, then 1, then 0 on consecutive cycles -> pend 4'b0011, 4'b0001, 4'b0000; pend_valid falls with the last ack.
- Bit1 pending, second rise on bit1 with no ack -> overflow=4'b0010, pend unchanged; clr_ovf -> overflow=0. Next, rise on bit1 on the same edge as ack idx 1 -> pend[1] stays 1, overflow stays 0.
- mask=4'b0100 with bit2 pending -> pend=0, pend_valid=0. Ack idx 2 -> ack_err pulses 1 cycle, pend_r unchanged. mask=0 -> pend=4'b0100 in the same cycle.
- Ack idx 0 with nothing pending -> ack_err=1 for one cycle, no state change. Overflow set on bit3 on the same edge as clr_ovf -> overflow=4'b1000.
- pend=4'b1111 and overflow=4'b0001, assert rst_n=0 for 1 cycle -> pend=0, overflow=0, ack_err=0 after that edge; irq_in still high gives no new event.
